// File: rtl/data_memory_be.sv
// Byte-addressable MIPS data memory: byte/half/word loads and stores, fault detection,
// a registered read port and a valid/ready dump engine. Optional macro WRITTEN_TRACK_EN limits the dump to written words.
module data_memory_be #(
    parameter int  ADDR_W = 32,
    parameter int  DEPTH  = 8192,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              read_valid,
    output logic              fault,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [IDX_W-1:0]  dump_index,
    output logic [31:0]       dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } dump_state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};

    logic [31:0]      mem_q [DEPTH];
    logic [IDX_W-1:0] idx_s;
    logic [1:0]       lane_s;
    logic             range_err_s, misalign_s, fault_s, wr_ok_s, rd_ok_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s, word_s, load_s;
    logic [7:0]       byte_s;
    logic [15:0]      half_s;

    logic [31:0]      read_data_q;
    logic             read_valid_q, fault_q;

    dump_state_e      state_q, state_d;
    logic             dump_valid_q, dump_valid_d;
    logic [IDX_W-1:0] dump_index_q, dump_index_d, next_idx_s;
    logic [31:0]      dump_data_q, dump_data_d;
    logic             dump_busy_q, dump_busy_d;
    logic             dump_done_q, dump_done_d;
    logic             elig_first_s, elig_next_s;

    // Request decode: word/lane split, legality checks and store lane steering.
    always_comb begin
        idx_s       = address[IDX_W+1:2];
        lane_s      = address[1:0];
        range_err_s = |(address >> (IDX_W + 2));
        misalign_s  = 1'b0;
        be_s        = 4'b0000;
        wdata_s     = write_data;
        case (mem_size)
            2'b00: begin
                be_s    = 4'b0001 << lane_s;
                wdata_s = {4{write_data[7:0]}};
            end
            2'b01: begin
                misalign_s = lane_s[0];
                be_s       = lane_s[1] ? 4'b1100 : 4'b0011;
                wdata_s    = {2{write_data[15:0]}};
            end
            2'b10: begin
                misalign_s = |lane_s;
                be_s       = 4'b1111;
            end
            default: misalign_s = 1'b1;
        endcase
        fault_s = (mem_read | mem_write)
                & (range_err_s | misalign_s | (mem_read & mem_write) | dump_busy_q);
        wr_ok_s = mem_write & ~fault_s;
        rd_ok_s = mem_read & ~fault_s;
    end

    // Load path: pick the addressed lane(s) and extend.
    always_comb begin
        word_s = mem_q[idx_s];
        byte_s = word_s[{lane_s, 3'b000} +: 8];
        half_s = lane_s[1] ? word_s[31:16] : word_s[15:0];
        case (mem_size)
            2'b00:   load_s = mem_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            2'b01:   load_s = mem_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            default: load_s = word_s;
        endcase
    end

    // Array store with byte enables; contents intentionally survive reset.
    always_ff @(posedge clock) begin
        if (wr_ok_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
        end
    end

    // Registered read port and fault pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_data_q  <= 32'h0000_0000;
            read_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            read_valid_q <= rd_ok_s;
            fault_q      <= fault_s;
            if (rd_ok_s) begin
                read_data_q <= load_s;
            end
        end
    end

`ifdef WRITTEN_TRACK_EN
    logic [DEPTH-1:0] written_q;

    // Per-word written flags, set by every accepted store.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            written_q <= {DEPTH{1'b0}};
        end else if (wr_ok_s) begin
            written_q[idx_s] <= 1'b1;
        end
    end

    assign elig_first_s = written_q[ZERO_IDX];
    assign elig_next_s  = written_q[next_idx_s];
`else
    assign elig_first_s = 1'b1;
    assign elig_next_s  = 1'b1;
`endif

    assign next_idx_s = dump_index_q + IDX_W'(1);

    // Dump FSM next state; a beat with valid low is a skipped (unwritten) word.
    always_comb begin
        state_d      = state_q;
        dump_valid_d = dump_valid_q;
        dump_index_d = dump_index_q;
        dump_data_d  = dump_data_q;
        case (state_q)
            ST_IDLE: begin
                if (dump_start) begin
                    state_d      = ST_STREAM;
                    dump_index_d = ZERO_IDX;
                    dump_valid_d = elig_first_s;
                    dump_data_d  = mem_q[ZERO_IDX];
                end else begin
                    dump_valid_d = 1'b0;
                end
            end
            ST_STREAM: begin
                if (dump_valid_q && !dump_ready) begin
                    dump_valid_d = 1'b1;
                end else if (dump_index_q == LAST_IDX) begin
                    state_d      = ST_DONE;
                    dump_valid_d = 1'b0;
                end else begin
                    dump_index_d = next_idx_s;
                    dump_valid_d = elig_next_s;
                    dump_data_d  = mem_q[next_idx_s];
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                dump_valid_d = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                dump_valid_d = 1'b0;
            end
        endcase
        dump_busy_d = (state_d != ST_IDLE);
        dump_done_d = (state_d == ST_DONE);
    end

    // Dump engine registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            dump_valid_q <= 1'b0;
            dump_index_q <= ZERO_IDX;
            dump_data_q  <= 32'h0000_0000;
            dump_busy_q  <= 1'b0;
            dump_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dump_valid_q <= dump_valid_d;
            dump_index_q <= dump_index_d;
            dump_data_q  <= dump_data_d;
            dump_busy_q  <= dump_busy_d;
            dump_done_q  <= dump_done_d;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign fault      = fault_q;
    assign dump_valid = dump_valid_q;
    assign dump_index = dump_index_q;
    assign dump_data  = dump_data_q;
    assign dump_busy  = dump_busy_q;
    assign dump_done  = dump_done_q;

endmodule

// File: tb/tb_data_memory_be.sv
// Directed bench for data_memory_be with DEPTH=16; expectations adapt when WRITTEN_TRACK_EN is defined.
module tb_data_memory_be;

    localparam int DEPTH = 16;
    localparam int IDX_W = 4;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;
`ifdef WRITTEN_TRACK_EN
    localparam int NB = 4;
    localparam int RST_AT = 2;
`else
    localparam int NB = DEPTH;
    localparam int RST_AT = 5;
`endif

    logic             clock = 1'b0;
    logic             reset_n;
    logic             mem_read, mem_write, mem_unsigned;
    logic [1:0]       mem_size;
    logic [31:0]      address, write_data, read_data, dump_data;
    logic             read_valid, fault, dump_start, dump_ready, dump_valid, dump_busy, dump_done;
    logic [IDX_W-1:0] dump_index;

    int checks = 0;
    int failures = 0;

    data_memory_be #(.ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .address(address), .write_data(write_data),
        .read_data(read_data), .read_valid(read_valid), .fault(fault),
        .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid),
        .dump_index(dump_index), .dump_data(dump_data), .dump_busy(dump_busy),
        .dump_done(dump_done)
    );

    always #5 clock = ~clock;

    // One request cycle; returns 1 time unit after the capturing edge.
    task automatic req(input logic rd, input logic wr, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clock);
        mem_read = rd; mem_write = wr; mem_size = size; mem_unsigned = uns;
        address = addr; write_data = wdata;
        @(posedge clock); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = SZ_W; mem_unsigned = 1'b0;
        address = 32'h0; write_data = 32'h0; dump_start = 1'b0; dump_ready = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({read_data, read_valid, fault, dump_valid, dump_index, dump_data, dump_busy, dump_done} !== 72'h0) begin
            failures++;
            $display("FAIL reset_state rd=%h rv=%b f=%b dv=%b di=%h dd=%h busy=%b done=%b expected all 0",
                     read_data, read_valid, fault, dump_valid, dump_index, dump_data, dump_busy, dump_done);
        end
        @(negedge clock); reset_n = 1'b1;
    endtask

    task automatic test_word;
        req(1'b0, 1'b1, SZ_W, 1'b0, 32'h0, 32'h8000_00FF);
        checks++;
        if (fault !== 1'b0 || read_valid !== 1'b0) begin
            failures++; $display("FAIL sw0 fault=%b read_valid=%b expected 0/0", fault, read_valid);
        end
        req(1'b1, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
        checks++;
        if (read_valid !== 1'b1 || read_data !== 32'h8000_00FF || fault !== 1'b0) begin
            failures++; $display("FAIL lw0 rv=%b data=%h fault=%b expected 1/800000ff/0", read_valid, read_data, fault);
        end
        @(posedge clock); #1;
        checks++;
        if (read_valid !== 1'b0 || read_data !== 32'h8000_00FF) begin
            failures++; $display("FAIL read_hold rv=%b data=%h expected 0/800000ff", read_valid, read_data);
        end
    endtask

    task automatic test_byte;
        req(1'b0, 1'b1, SZ_W, 1'b0, 32'h8, 32'h1122_3344);
        req(1'b0, 1'b1, SZ_B, 1'b0, 32'hA, 32'h0000_00AA);
        req(1'b1, 1'b0, SZ_B, 1'b1, 32'hA, 32'h0);
        checks++;
        if (read_valid !== 1'b1 || read_data !== 32'h0000_00AA) begin
            failures++; $display("FAIL lbu_a rv=%b data=%h expected 1/000000aa", read_valid, read_data);
        end
        req(1'b1, 1'b0, SZ_B, 1'b0, 32'hA, 32'h0);
        checks++;
        if (read_data !== 32'hFFFF_FFAA) begin
            failures++; $display("FAIL lb_a data=%h expected ffffffaa", read_data);
        end
        req(1'b1, 1'b0, SZ_W, 1'b0, 32'h8, 32'h0);
        checks++;
        if (read_data !== 32'h11AA_3344) begin
            failures++; $display("FAIL lw_8 data=%h expected 11aa3344", read_data);
        end
        req(1'b1, 1'b0, SZ_B, 1'b0, 32'h8, 32'h0);
        checks++;
        if (read_data !== 32'h0000_0044) begin
            failures++; $display("FAIL lb_8 data=%h expected 00000044", read_data);
        end
    endtask

    task automatic test_half;
        req(1'b0, 1'b1, SZ_H, 1'b0, 32'h6, 32'h0000_BEEF);
        req(1'b1, 1'b0, SZ_H, 1'b0, 32'h6, 32'h0);
        checks++;
        if (read_valid !== 1'b1 || read_data !== 32'hFFFF_BEEF) begin
            failures++; $display("FAIL lh_6 rv=%b data=%h expected 1/ffffbeef", read_valid, read_data);
        end
        req(1'b1, 1'b0, SZ_H, 1'b1, 32'h6, 32'h0);
        checks++;
        if (read_data !== 32'h0000_BEEF) begin
            failures++; $display("FAIL lhu_6 data=%h expected 0000beef", read_data);
        end
        req(1'b1, 1'b0, SZ_W, 1'b0, 32'h3, 32'h0);
        checks++;
        if (fault !== 1'b1 || read_valid !== 1'b0 || read_data !== 32'h0000_BEEF) begin
            failures++; $display("FAIL lw_misaligned fault=%b rv=%b data=%h expected 1/0/0000beef", fault, read_valid, read_data);
        end
        req(1'b0, 1'b1, SZ_H, 1'b0, 32'h5, 32'h0000_1234);
        checks++;
        if (fault !== 1'b1) begin
            failures++; $display("FAIL sh_misaligned fault=%b expected 1", fault);
        end
        req(1'b0, 1'b1, SZ_X, 1'b0, 32'h8, 32'h0);
        checks++;
        if (fault !== 1'b1) begin
            failures++; $display("FAIL size_reserved fault=%b expected 1", fault);
        end
        req(1'b1, 1'b0, SZ_W, 1'b0, 32'h8, 32'h0);
        checks++;
        if (fault !== 1'b0 || read_data !== 32'h11AA_3344) begin
            failures++; $display("FAIL unchanged_8 fault=%b data=%h expected 0/11aa3344", fault, read_data);
        end
    endtask

    task automatic test_faults;
        req(1'b0, 1'b1, SZ_W, 1'b0, 32'h40, 32'hDEAD_BEEF);
        checks++;
        if (fault !== 1'b1) begin
            failures++; $display("FAIL range_write fault=%b expected 1", fault);
        end
        req(1'b1, 1'b1, SZ_W, 1'b0, 32'h0, 32'h0);
        checks++;
        if (fault !== 1'b1 || read_valid !== 1'b0) begin
            failures++; $display("FAIL rd_wr_same fault=%b rv=%b expected 1/0", fault, read_valid);
        end
        req(1'b1, 1'b0, SZ_W, 1'b0, 32'h8000_0000, 32'h0);
        checks++;
        if (fault !== 1'b1 || read_valid !== 1'b0) begin
            failures++; $display("FAIL range_read fault=%b rv=%b expected 1/0", fault, read_valid);
        end
        req(1'b1, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
        checks++;
        if (fault !== 1'b0 || read_data !== 32'h8000_00FF) begin
            failures++; $display("FAIL word0_kept fault=%b data=%h expected 0/800000ff", fault, read_data);
        end
    endtask

    task automatic test_back_to_back;
        req(1'b0, 1'b1, SZ_W, 1'b0, 32'hC, 32'h1234_5678);
        req(1'b1, 1'b0, SZ_W, 1'b0, 32'hC, 32'h0);
        checks++;
        if (read_valid !== 1'b1 || read_data !== 32'h1234_5678) begin
            failures++; $display("FAIL wr_then_rd rv=%b data=%h expected 1/12345678", read_valid, read_data);
        end
        req(1'b0, 1'b1, SZ_B, 1'b0, 32'hF, 32'h0000_0055);
        req(1'b1, 1'b0, SZ_W, 1'b0, 32'hC, 32'h0);
        checks++;
        if (read_data !== 32'h5534_5678) begin
            failures++; $display("FAIL sb_lane3 data=%h expected 55345678", read_data);
        end
    endtask

    task automatic test_dump;
        logic [31:0]      exp_data [4];
        logic [IDX_W-1:0] h_idx;
        logic [31:0]      h_data;
        bit               stalled, last_prev, done_seen, xfer;
        int               n;
        exp_data[0] = 32'h1; exp_data[1] = 32'h2; exp_data[2] = 32'h3; exp_data[3] = 32'h5534_5678;
        req(1'b0, 1'b1, SZ_W, 1'b0, 32'h0, 32'h1);
        req(1'b0, 1'b1, SZ_W, 1'b0, 32'h4, 32'h2);
        req(1'b0, 1'b1, SZ_W, 1'b0, 32'h8, 32'h3);
        @(negedge clock); dump_start = 1'b1; dump_ready = 1'b0;
        @(negedge clock); dump_start = 1'b0;
        checks++;
        if (dump_busy !== 1'b1 || dump_valid !== 1'b1 || dump_index !== 4'd0 || dump_data !== 32'h1) begin
            failures++; $display("FAIL dump_first busy=%b dv=%b idx=%0d data=%h expected 1/1/0/00000001",
                                 dump_busy, dump_valid, dump_index, dump_data);
        end
        req(1'b0, 1'b1, SZ_W, 1'b0, 32'h0, 32'h0000_DEAD);
        checks++;
        if (fault !== 1'b1) begin
            failures++; $display("FAIL req_during_dump fault=%b expected 1", fault);
        end
        @(negedge clock); dump_start = 1'b1;
        @(negedge clock); dump_start = 1'b0;
        checks++;
        if (dump_valid !== 1'b1 || dump_index !== 4'd0 || dump_data !== 32'h1) begin
            failures++; $display("FAIL stall_start dv=%b idx=%0d data=%h expected 1/0/00000001", dump_valid, dump_index, dump_data);
        end
        n = 0; stalled = 1'b0; last_prev = 1'b0; done_seen = 1'b0;
        for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
            @(negedge clock);
`ifndef WRITTEN_TRACK_EN
            if (last_prev) begin
                checks++;
                if (dump_done !== 1'b1) begin
                    failures++; $display("FAIL done_after_last done=%b expected 1", dump_done);
                end
            end
`endif
            if (dump_done === 1'b1) begin
                done_seen = 1'b1;
            end else begin
                if (stalled) begin
                    checks++;
                    if (dump_valid !== 1'b1 || dump_index !== h_idx || dump_data !== h_data) begin
                        failures++; $display("FAIL stall_hold dv=%b idx=%0d data=%h expected 1/%0d/%h",
                                             dump_valid, dump_index, dump_data, h_idx, h_data);
                    end
                end
                dump_ready = ((cyc % 2) == 0);
                xfer = dump_valid && dump_ready;
                stalled = dump_valid && !dump_ready;
                h_idx = dump_index; h_data = dump_data;
                last_prev = 1'b0;
                if (xfer) begin
                    checks++;
                    if (dump_index !== IDX_W'(n) || (n < 4 && dump_data !== exp_data[n])) begin
                        failures++; $display("FAIL dump_beat n=%0d idx=%0d data=%h expected idx %0d", n, dump_index, dump_data, n);
                    end
                    n++;
                    last_prev = (n == NB);
                end
            end
        end
        checks++;
        if (!done_seen || n != NB) begin
            failures++; $display("FAIL dump_beats count=%0d done=%b expected %0d/1", n, done_seen, NB);
        end
        @(negedge clock); dump_ready = 1'b0;
        checks++;
        if (dump_done !== 1'b0 || dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
            failures++; $display("FAIL dump_idle done=%b busy=%b dv=%b expected 0/0/0", dump_done, dump_busy, dump_valid);
        end
        req(1'b1, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
        checks++;
        if (read_data !== 32'h1) begin
            failures++; $display("FAIL dump_write_blocked data=%h expected 00000001", read_data);
        end
    endtask

    task automatic test_reset_mid_dump;
        bit hit;
        hit = 1'b0;
        @(negedge clock); dump_start = 1'b1; dump_ready = 1'b1;
        @(negedge clock); dump_start = 1'b0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            if (dump_valid === 1'b1 && dump_index === IDX_W'(RST_AT)) begin
                hit = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        checks++;
        if (!hit) begin
            failures++; $display("FAIL dump_wait_timeout idx=%0d expected %0d", dump_index, RST_AT);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({read_data, read_valid, fault, dump_valid, dump_index, dump_data, dump_busy, dump_done} !== 72'h0) begin
            failures++; $display("FAIL async_reset rd=%h rv=%b dv=%b di=%h dd=%h busy=%b done=%b expected all 0",
                                 read_data, read_valid, dump_valid, dump_index, dump_data, dump_busy, dump_done);
        end
        dump_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clock);
            checks++;
            if (dump_done !== 1'b0 || dump_busy !== 1'b0) begin
                failures++; $display("FAIL no_done_after_abort done=%b busy=%b expected 0/0", dump_done, dump_busy);
            end
        end
        req(1'b1, 1'b0, SZ_W, 1'b0, 32'h4, 32'h0);
        checks++;
        if (read_valid !== 1'b1 || read_data !== 32'h2) begin
            failures++; $display("FAIL retained_4 rv=%b data=%h expected 1/00000002", read_valid, read_data);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_faults();
        test_back_to_back();
        test_dump();
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
